// File: rtl/fetch_queue.sv
// fetch_queue: in-order {pc, inst} buffer between fetch and decode with flush on redirect.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_inst,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_inst,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  logic [XLEN-1:0] pc_mem [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0] head_q, head_d, tail_q, tail_d;
  logic [AW:0] count_q, count_d;
  logic push, pop;
  assign in_ready  = count_q != FULL;
  assign out_valid = count_q != '0;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  // Storage is never exposed while empty: decode sees a NOP at pc 0 instead.
  assign out_pc    = out_valid ? pc_mem[head_q] : '0;
  assign out_inst  = out_valid ? inst_mem[head_q] : XLEN'(32'h00000013);
  always_comb begin
    head_d  = flush ? '0 : head_q + AW'(pop);
    tail_d  = flush ? '0 : tail_q + AW'(push);
    count_d = flush ? '0 : count_q + (AW+1)'(push) - (AW+1)'(pop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[tail_q]   <= in_pc;
      inst_mem[tail_q] <= in_inst;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard queue checked by an output monitor.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  logic clk = 0, rst = 1, in_valid = 0, flush = 0, out_ready = 0;
  logic [XLEN-1:0] in_pc = '0, in_inst = '0;
  logic in_ready, out_valid;
  logic [XLEN-1:0] out_pc, out_inst;
  logic [$clog2(DEPTH):0] count;
  int n_chk = 0, n_fail = 0;
  logic [63:0] exp_q [$];

  fetch_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return pc ^ 32'hA5000013;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1;
      in_pc = pc0 + 32'(4 * i);
      in_inst = inst_of(in_pc);
      tick;
    end
    in_valid = 0;
  endtask

  task automatic wait_empty;
    int k;
    k = 0;
    out_ready = 1;
    while (count != 0 && k < 50) begin
      tick;
      k++;
    end
    chk("drain_timeout", 32'(k < 50), 32'd1);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    out_ready = 0;
  endtask

  // Expected stream: every accepted push; a flush or reset drops everything queued.
  always @(negedge clk) begin
    if (rst || flush) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back({in_pc, in_inst});
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("count_le_depth", 32'(count <= DEPTH), 32'd1);
      if (!flush && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_out: got pc %h expected no output", out_pc);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("out_pc", out_pc, e[63:32]);
          chk("out_inst", out_inst, e[31:0]);
        end
      end
    end
  end

  initial begin
    int pushes, cyc;
    logic [31:0] pc;
    tick;
    chk("rst_count", 32'(count), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 32'h00000013);
    rst = 0;
    tick;
    // Async reset with two entries held
    push_n(32'h40, 2);
    chk("pre_rst_count", 32'(count), 2);
    #2 rst = 1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_out_valid", 32'(out_valid), 0);
    chk("async_rst_in_ready", 32'(in_ready), 1);
    chk("async_rst_out_inst", out_inst, 32'h00000013);
    tick;
    rst = 0;
    in_valid = 1; in_pc = 32'h100; in_inst = 32'h00500093;
    chk("no_bypass", 32'(out_valid), 0);
    tick;
    in_valid = 0;
    chk("lat_out_valid", 32'(out_valid), 1);
    chk("lat_out_pc", out_pc, 32'h100);
    chk("lat_out_inst", out_inst, 32'h00500093);
    wait_empty;
    // Fill and drain
    push_n(32'h0, 4);
    chk("full_count", 32'(count), 4);
    chk("full_in_ready", 32'(in_ready), 0);
    in_valid = 1; in_pc = 32'h10; in_inst = inst_of(32'h10);
    tick; tick;
    chk("held_count", 32'(count), 4);
    chk("held_in_ready", 32'(in_ready), 0);
    chk("full_head_pc", out_pc, 32'h0);
    out_ready = 1;
    tick;
    chk("in_ready_after_pop", 32'(in_ready), 1);
    chk("count_after_pop", 32'(count), 3);
    tick;
    in_valid = 0;
    chk("count_after_refill", 32'(count), 3);
    wait_empty;
    // Simultaneous push/pop at count=2
    push_n(32'h1000, 2);
    chk("pp_start_count", 32'(count), 2);
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1;
      in_pc = 32'h1008 + 32'(4 * i);
      in_inst = inst_of(in_pc);
      tick;
      chk("pp_count", 32'(count), 2);
    end
    in_valid = 0;
    wait_empty;
    // Randomized wrap-around
    pc = 32'h5000; pushes = 0; cyc = 0;
    while (pushes < 3 * DEPTH && cyc < 300) begin
      in_valid = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      in_pc = pc;
      in_inst = inst_of(pc);
      if (in_valid && in_ready) begin
        pc += 4;
        pushes++;
      end
      tick;
      cyc++;
    end
    in_valid = 0;
    chk("wrap_pushes", 32'(pushes), 32'(3 * DEPTH));
    wait_empty;
    // Flush with concurrent push and pop
    push_n(32'h2000, 3);
    chk("fl_count", 32'(count), 3);
    flush = 1; out_ready = 1;
    in_valid = 1; in_pc = 32'h200; in_inst = inst_of(32'h200);
    #1;
    chk("fl_pre_head_pc", out_pc, 32'h2000);
    tick;
    flush = 0;
    chk("fl_count_after", 32'(count), 0);
    chk("fl_out_valid", 32'(out_valid), 0);
    chk("fl_in_ready", 32'(in_ready), 1);
    out_ready = 0;
    in_pc = 32'h300; in_inst = inst_of(32'h300);
    tick;
    in_valid = 0;
    chk("fl_new_valid", 32'(out_valid), 1);
    chk("fl_new_pc", out_pc, 32'h300);
    wait_empty;
    // Flush while full, producer holding a pair
    push_n(32'h3000, 4);
    in_valid = 1; in_pc = 32'h4000; in_inst = inst_of(32'h4000);
    chk("ff_in_ready", 32'(in_ready), 0);
    flush = 1;
    tick;
    flush = 0;
    chk("ff_count", 32'(count), 0);
    tick;
    in_valid = 0;
    chk("ff_refill_count", 32'(count), 1);
    chk("ff_refill_pc", out_pc, 32'h4000);
    wait_empty;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction queue between the fetch stage and decode. It captures {pc, inst} pairs produced by fetch, buffers up to DEPTH entries in order, and presents the oldest entry to decode under a valid/ready handshake. A synchronous flush discards all buffered entries on a control-flow redirect (branch, jump, trap) so that decode never sees wrong-path instructions.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2
- XLEN, 32, width of pc and inst
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  fetch presents a pair on in_pc/in_inst
- in_ready  output  1  queue accepts the pair this cycle
- in_pc  input  XLEN  pc of the fetched instruction
- in_inst  input  XLEN  fetched instruction word
- flush  input  1  discard all entries; redirect from execute/branch unit
- out_valid  output  1  head entry is valid for decode
- out_ready  input  1  decode consumes the head this cycle
- out_pc  output  XLEN  pc of the head entry
- out_inst  output  XLEN  instruction of the head entry
- count  output  $clog2(DEPTH)+1  number of occupied entries

## Operation
- Storage: DEPTH-entry circular buffer with head (read) and tail (write) pointers of $clog2(DEPTH) bits and an occupancy counter.
- push = in_valid && in_ready; pop = out_valid && out_ready.
- in_ready = (count != DEPTH). It does not depend on out_ready, so a push into a full queue is never accepted, even when a pop occurs in the same cycle.
- out_valid = (count != 0). out_pc/out_inst are read combinationally from the head entry.
- When empty: out_pc = 0 and out_inst = 32'h00000013 (NOP). Storage contents are never exposed while out_valid=0.
- Push writes {in_pc, in_inst} to the tail and advances tail by 1. Pop advances head by 1. Both pointers wrap modulo DEPTH.
- Push and pop in the same cycle (count not 0 and not DEPTH): both pointers advance and count is unchanged.
- Count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Flush has priority over everything. At the next edge head=0, tail=0 and count=0. A push or pop asserted in the flush cycle has no effect. Data outputs still reflect the pre-flush head during the flush cycle.
- Protocol requirement on the producer: while in_valid && !in_ready, fetch holds in_pc/in_inst stable. The queue does not check this.
- rst asserted: head=0, tail=0, count=0 immediately, without waiting for a clock edge. Storage is not cleared. Reset mid-operation drops all entries.

## Timing
- Reset values: count=0, out_valid=0, in_ready=1, out_pc=0, out_inst=32'h00000013.
- Latency: a pair pushed at edge N is visible on out_* with out_valid=1 after edge N. There is no same-cycle bypass from input to output.
- Throughput: one push and one pop per cycle sustained when 0 < count < DEPTH.
- Full: in_ready drops in the cycle after the DEPTH-th push. It rises in the cycle after the first pop.
- Flush: out_valid=0 and in_ready=1 in the cycle after flush is high. A new push is accepted in that cycle.
- All outputs except the data read are functions of registered state. in_ready and out_valid have no combinational path from any input.

## Test plan
- Reset: assert rst mid-clock with 2 entries held. count=0, out_valid=0, in_ready=1 and out_inst=0x00000013 before the next edge. After release, the first push {0x100, 0x00500093} appears at the output one cycle later.
- Fill/drain: push pcs 0x0, 0x4, 0x8, 0xC with out_ready=0. count reaches 4 and in_ready=0. A fifth pair {0x10} is held and is not accepted. Raise out_ready: outputs appear in order 0x0, 0x4, 0x8, 0xC, then 0x10, with no loss or duplication.
- Simultaneous push/pop: from count=2, run in_valid=out_ready=1 for 10 cycles. count stays 2 and the output pc sequence is strictly +4 per cycle.
- Wrap-around: 3 × DEPTH randomized push/pop with pcs incrementing by 4. The output stream equals the input stream, including pointers passing index DEPTH-1 → 0.
- Flush: with count=3, assert flush together with in_valid (pc 0x200) and out_ready. Next cycle count=0 and out_valid=0, and 0x200 never appears. A push of 0x300 in that cycle appears at the output one cycle later.
- Flush while full with in_valid held high: the queue empties, then refills starting from the held pair. count never exceeds DEPTH.
